risc_trace_fifo: RTL and testbench

//  Downstream observer of the RISC core. Samples the core's PC and resOut buses
//  and records one (PC, result) pair each time the PC changes, i.e. once per

---
 rtl/risc_trace_fifo.sv | 122 ++++++++++++
 tb/tb_risc_trace_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/risc_trace_fifo.sv
// risc_trace_fifo: records one (PC, result) pair per retired instruction of the
// RISC core by watching for PC changes. Pairs are queued in a first-word-fall-
// through FIFO and drained over a valid/ready port. Entries arriving while the
// FIFO is full are dropped and counted.
module risc_trace_fifo #(
    parameter int ADDR_W = 4,
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int DROP_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [PC_W-1:0]   core_pc,
    input  logic [DATA_W-1:0] core_res,
    input  logic              trace_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_res,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);

    logic [PC_W-1:0]   mem_pc_q  [DEPTH];
    logic [DATA_W-1:0] mem_res_q [DEPTH];

    logic [PC_W-1:0]   last_pc_q,  last_pc_d;
    logic              primed_q,   primed_d;
    logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [ADDR_W:0]   count_q,    count_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic cap;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // Capture/push/pop decisions and next-state for pointers, count and drop stats
    always_comb begin
        last_pc_d  = core_pc;
        primed_d   = 1'b1;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        // The first enabled cycle after reset captures regardless of last_pc,
        // so a PC equal to the pre-reset one is still recorded.
        cap  = trace_en & (~primed_q | (core_pc != last_pc_q));
        full = (count_q == CNT_FULL);
        pop  = out_valid & out_ready;
        // When full, a simultaneous pop frees the slot being written.
        push = cap & (~full | pop);
        drop = cap & full & ~pop;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + DROP_ONE;
            end
        end
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST) begin
            last_pc_q  <= '0;
            primed_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            last_pc_q  <= last_pc_d;
            primed_q   <= primed_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage array: written at wr_ptr on push; contents need no reset
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]  <= core_pc;
            mem_res_q[wr_ptr_q] <= core_res;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_pc    = mem_pc_q[rd_ptr_q];
    assign out_res   = mem_res_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_risc_trace_fifo.sv
// Bench for risc_trace_fifo: expected (PC, result) pairs are queued as stimulus
// is driven and compared as the FIFO hands them out.
module tb_risc_trace_fifo;

    logic        CLK;
    logic        RST;
    logic [31:0] core_pc;
    logic [31:0] core_res;
    logic        trace_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_res;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;

    int total;
    int bad;
    logic [63:0] exp_q [$];

    risc_trace_fifo #(
        .ADDR_W(4), .PC_W(32), .DATA_W(32), .DROP_W(16)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .core_pc  (core_pc),
        .core_res (core_res),
        .trace_en (trace_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc   (out_pc),
        .out_res  (out_res),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive one cycle of core activity; exp_cap says whether the bench expects
    // this cycle to produce a stored entry.
    task automatic drive(input logic [31:0] pc, input logic [31:0] res, input bit exp_cap);
        core_pc  = pc;
        core_res = res;
        trace_en = 1'b1;
        if (exp_cap) exp_q.push_back({pc, res});
        tick();
    endtask

    task automatic drain(input string tag);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (out_valid && n < 40) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: a pop takes effect at the coming edge, so compare the head now
    always @(negedge CLK) begin
        if (RST && out_valid && out_ready) begin
            chk("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                chk("sb_pair", {out_pc, out_res}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        total     = 0;
        bad       = 0;
        RST       = 1'b0;
        core_pc   = '0;
        core_res  = '0;
        trace_en  = 1'b0;
        out_ready = 1'b0;

        // Reset held two cycles
        tick();
        tick();
        chk("rst_valid",    {63'd0, out_valid}, 64'd0);
        chk("rst_count",    64'(count), 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        chk("rst_drop",     64'(drop_cnt), 64'd0);

        // Ordering: first enabled cycle after reset captures PC 0
        RST = 1'b1;
        drive(32'h0, 32'h11, 1'b1);
        drive(32'h4, 32'h22, 1'b1);
        drive(32'h8, 32'h33, 1'b1);
        trace_en = 1'b0;
        tick();
        chk("ord_count", 64'(count), 64'd3);
        chk("ord_head",  {out_pc, out_res}, {32'h0, 32'h11});
        drain("ord");

        // Stall: a held PC produces one entry
        for (int i = 0; i < 5; i++) drive(32'h10, 32'h100 + 32'(i), i == 0);
        drive(32'h14, 32'h200, 1'b1);
        trace_en = 1'b0;
        tick();
        chk("stall_count", 64'(count), 64'd2);
        drain("stall");

        // Overflow: 18 distinct PCs into a 16-deep FIFO
        for (int i = 0; i < 18; i++)
            drive(32'h100 + 32'(4 * i), 32'(i * 3 + 7), i < 16);
        trace_en = 1'b0;
        tick();
        chk("ovf_count", 64'(count), 64'd16);
        chk("ovf_flag",  {63'd0, overflow}, 64'd1);
        chk("ovf_drop",  64'(drop_cnt), 64'd2);

        // Full with simultaneous push and pop: no drop, count stays full
        out_ready = 1'b1;
        drive(32'h200, 32'h55, 1'b1);
        out_ready = 1'b0;
        trace_en  = 1'b0;
        tick();
        chk("fpp_count", 64'(count), 64'd16);
        chk("fpp_drop",  64'(drop_cnt), 64'd2);
        chk("fpp_head",  64'(out_pc), 64'h104);
        drain("fpp");
        chk("fpp_sticky", {63'd0, overflow}, 64'd1);

        // Mid-operation reset discards five stored entries
        for (int i = 0; i < 5; i++) drive(32'h300 + 32'(4 * i), 32'h40 + 32'(i), 1'b1);
        trace_en = 1'b0;
        tick();
        chk("mid_count", 64'(count), 64'd5);
        RST = 1'b0;
        exp_q.delete();
        tick();
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_ovf",   {63'd0, overflow}, 64'd0);
        chk("mid_rst_drop",  64'(drop_cnt), 64'd0);

        // Same PC as before reset, captured into an empty FIFO with out_ready high
        RST       = 1'b1;
        out_ready = 1'b1;
        drive(32'h310, 32'h99, 1'b1);
        out_ready = 1'b0;
        trace_en  = 1'b0;
        chk("post_count", 64'(count), 64'd1);
        chk("post_head",  {out_pc, out_res}, {32'h310, 32'h99});
        drain("post");

        // Disabled capture: PC changes are ignored
        core_pc = 32'h500;
        tick();
        core_pc = 32'h504;
        tick();
        chk("dis_count", 64'(count), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
